// File: rtl/spike_dispatcher.sv
// Collects neuron spikes per time step and replays them as synapse addresses, lowest line first.
// Optional SPIKE_COUNT_EN adds a 16-bit count of addresses accepted in the last burst.
module spike_dispatcher #(
  parameter int NUM_NEURONS = 8,
  parameter int ADDR_W      = 10,
  parameter int BASE_ADDR   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   time_step,
  input  logic [NUM_NEURONS-1:0] spike_in,
  input  logic                   ready,
  input  logic                   clr_overrun,
  output logic [ADDR_W-1:0]      address,
  output logic                   addr_valid,
  output logic                   busy,
  output logic                   burst_done,
  output logic                   overrun
`ifdef SPIKE_COUNT_EN
  ,
  output logic [15:0]            spike_count
`endif
);

  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

  state_t                 state, state_next;
  logic [NUM_NEURONS-1:0] pending, send_buf, buf_next, buf_cleared;
  logic [ADDR_W-1:0]      addr_next;
  logic                   valid_next;
  logic                   accept;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [NUM_NEURONS-1:0] v);
    logic [IDX_W-1:0] idx;
    logic             found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
      if (!found && v[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
    return ADDR_W'(BASE_ADDR) + ADDR_W'(idx);
  endfunction

  assign accept     = addr_valid & ready;
  assign busy       = (state != IDLE);
  assign burst_done = (state == DONE);
  // The presented address is always the lowest set bit, so acceptance just drops that bit.
  assign buf_cleared = send_buf & (send_buf - NUM_NEURONS'(1));

  always_comb begin
    state_next = state;
    buf_next   = send_buf;
    addr_next  = address;
    valid_next = addr_valid;
    case (state)
      IDLE: begin
        addr_next  = '0;
        valid_next = 1'b0;
        if (time_step) begin
          state_next = LOAD;
          buf_next   = pending | spike_in;
        end
      end
      LOAD: begin
        if (|send_buf) begin
          state_next = SEND;
          addr_next  = addr_of(send_buf);
          valid_next = 1'b1;
        end else begin
          state_next = DONE;
        end
      end
      SEND: begin
        if (accept) begin
          buf_next = buf_cleared;
          if (|buf_cleared) begin
            addr_next = addr_of(buf_cleared);
          end else begin
            state_next = DONE;
            addr_next  = '0;
            valid_next = 1'b0;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      pending    <= '0;
      send_buf   <= '0;
      address    <= '0;
      addr_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_next;
      send_buf   <= buf_next;
      address    <= addr_next;
      addr_valid <= valid_next;
      if (state == IDLE && time_step) pending <= '0;
      else                            pending <= pending | spike_in;
      overrun    <= (time_step & busy) | (overrun & ~clr_overrun);
    end
  end

`ifdef SPIKE_COUNT_EN
  logic [15:0] burst_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      burst_cnt   <= '0;
      spike_count <= '0;
    end else begin
      if (state == LOAD)                  burst_cnt <= '0;
      else if (accept && burst_cnt != '1) burst_cnt <= burst_cnt + 16'd1;
      if (state == DONE) spike_count <= burst_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_spike_dispatcher.sv
// Directed bench for spike_dispatcher: stimulus pushes expected addresses (-1 = burst_done)
// into a queue; a negedge monitor pops and compares each accepted address / burst_done.
module tb_spike_dispatcher;
  localparam int NN = 8;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst, time_step, ready, clr_overrun;
  logic [NN-1:0] spike_in;
  logic [AW-1:0] address;
  logic          addr_valid, busy, burst_done, overrun;
`ifdef SPIKE_COUNT_EN
  logic [15:0]   spike_count;
`endif

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  spike_dispatcher #(.NUM_NEURONS(NN), .ADDR_W(AW), .BASE_ADDR(1)) dut (
    .clk(clk), .rst(rst), .time_step(time_step), .spike_in(spike_in),
    .ready(ready), .clr_overrun(clr_overrun), .address(address),
    .addr_valid(addr_valid), .busy(busy), .burst_done(burst_done),
    .overrun(overrun)
`ifdef SPIKE_COUNT_EN
    , .spike_count(spike_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard pops, hold-stability and idle-zero checks.
  logic          hold_prev = 1'b0;
  logic [AW-1:0] addr_prev = '0;
  always @(negedge clk) begin
    if (hold_prev) begin
      check("hold_valid", 32'(addr_valid), 32'd1);
      check("hold_addr", 32'(address), 32'(addr_prev));
    end
    if (addr_valid === 1'b0) check("idle_addr_zero", 32'(address), 32'd0);
    if (addr_valid === 1'b1 && ready === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_addr", 32'(address), 32'hFFFF_FFFF);
      else check("sb_addr", 32'(address), 32'(exp_q.pop_front()));
    end
    if (burst_done === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else check("sb_done", 32'(exp_q.pop_front()), 32'hFFFF_FFFF);
    end
    hold_prev = (addr_valid === 1'b1 && ready === 1'b0 && rst === 1'b1);
    addr_prev = address;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ts();
    time_step = 1'b1;
    tick();
    time_step = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (burst_done !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (burst_done !== 1'b1) check({name, "_timeout"}, 32'd0, 32'd1);
    tick();
  endtask

  task automatic check_count(input logic [15:0] exp);
`ifdef SPIKE_COUNT_EN
    check("spike_count", 32'(spike_count), 32'(exp));
`else
    if (exp == 16'hFFFF) check("spike_count_dummy", 32'd0, 32'd1);
`endif
  endtask

  initial begin
    rst = 1'b0; time_step = 1'b0; ready = 1'b1; clr_overrun = 1'b0; spike_in = '0;
    tick(); tick();
    check("rst_addr", 32'(address), 32'd0);
    check("rst_valid", 32'(addr_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(burst_done), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b1;
    tick();

    // Lines 0,2,5 -> 1,3,6 consecutively, latency 2.
    exp_q.push_back(1); exp_q.push_back(3); exp_q.push_back(6); exp_q.push_back(-1);
    spike_in = 8'b0010_0101; tick(); spike_in = '0;
    pulse_ts();
    check("t1_load_valid", 32'(addr_valid), 32'd0);
    check("t1_load_busy", 32'(busy), 32'd1);
    tick();
    check("t1_lat_valid", 32'(addr_valid), 32'd1);
    check("t1_lat_addr", 32'(address), 32'd1);
    tick(); check("t1_addr2", 32'(address), 32'd3);
    tick(); check("t1_addr3", 32'(address), 32'd6);
    tick(); check("t1_done", 32'(burst_done), 32'd1);
    check("t1_done_valid", 32'(addr_valid), 32'd0);
    tick(); check("t1_idle", 32'(busy), 32'd0);
    check("t1_done_clr", 32'(burst_done), 32'd0);
    check_count(16'd3);

    // Empty burst: burst_done 2 cycles after the pulse.
    exp_q.push_back(-1);
    pulse_ts();
    check("t2_no_done_yet", 32'(burst_done), 32'd0);
    tick();
    check("t2_done", 32'(burst_done), 32'd1);
    check("t2_valid", 32'(addr_valid), 32'd0);
    tick();
    check_count(16'd0);

    // Backpressure: address 2 held 4 cycles, then 4.
    exp_q.push_back(2); exp_q.push_back(4); exp_q.push_back(-1);
    spike_in = 8'b0000_1010; ready = 1'b0; tick(); spike_in = '0;
    pulse_ts(); tick();
    for (int i = 0; i < 4; i++) begin
      check("t3_hold_addr", 32'(address), 32'd2);
      if (i < 3) tick();
    end
    ready = 1'b1; tick();
    check("t3_addr2", 32'(address), 32'd4);
    tick(); check("t3_done", 32'(burst_done), 32'd1);
    tick();

    // Overrun during a 3-event burst; line 7 emitted with the next step.
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(-1);
    spike_in = 8'b0000_0111; tick(); spike_in = '0;
    pulse_ts(); tick();
    spike_in = 8'b1000_0000; time_step = 1'b1; tick(); spike_in = '0; time_step = 1'b0;
    check("t4_overrun_set", 32'(overrun), 32'd1);
    wait_done("t4");
    check("t4_overrun_sticky", 32'(overrun), 32'd1);
    exp_q.push_back(8); exp_q.push_back(-1);
    pulse_ts();
    // Simultaneous set and clear: set wins.
    time_step = 1'b1; clr_overrun = 1'b1; tick(); time_step = 1'b0; clr_overrun = 1'b0;
    check("t4_set_wins", 32'(overrun), 32'd1);
    wait_done("t4b");
    clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
    check("t4_overrun_clr", 32'(overrun), 32'd0);

    // Spike in the same cycle as time_step; pending empty afterwards.
    exp_q.push_back(5); exp_q.push_back(-1);
    spike_in = 8'b0001_0000; time_step = 1'b1; tick(); spike_in = '0; time_step = 1'b0;
    wait_done("t5");
    exp_q.push_back(-1);
    pulse_ts();
    wait_done("t5b");

    // Reset after the first of three addresses is accepted.
    exp_q.push_back(1);
    spike_in = 8'b0000_0111; tick(); spike_in = '0;
    pulse_ts(); tick();
    check("t6_first", 32'(address), 32'd1);
    rst = 1'b0; tick();
    check("t6_addr", 32'(address), 32'd0);
    check("t6_valid", 32'(addr_valid), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t6_no_done", 32'(burst_done), 32'd0);
      tick();
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spike_dispatcher.md
SPIKE_DISPATCHER -- requirements
Module: spike_dispatcher

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 8: number of source neuron spike lines (2..64).
REQ-002 SHALL have parameter ADDR_W, default 10: width of emitted synapse address, matching the neuron address input.
REQ-003 SHALL have parameter BASE_ADDR, default 1: address emitted for spike line 0; address 0 is reserved as "no input".
REQ-004 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1: synchronous, active-low reset.
REQ-006 SHALL have port time_step  input  1: one-cycle pulse closing the current time step.
REQ-007 SHALL have port spike_in  input  NUM_NEURONS: spike outputs of the source neurons; bit i high = neuron i fired this cycle.
REQ-008 SHALL have port ready  input  1: downstream accepts the address on the current cycle.
REQ-009 SHALL have port clr_overrun  input  1: clears the overrun flag.
REQ-010 SHALL have port address  output  ADDR_W: registered synapse address driven to downstream neurons; 0 when idle.
REQ-011 SHALL have port addr_valid  output  1: address carries a spike event.
REQ-012 SHALL have port busy  output  1: FSM not in IDLE.
REQ-013 SHALL have port burst_done  output  1: one-cycle pulse after the last address of a burst is accepted.
REQ-014 SHALL have port overrun  output  1: sticky; time_step arrived while busy.

Function
REQ-015 SHALL OR spike_in into a pending register every cycle; a bit stays set until snapshotted.
REQ-016 SHALL, on time_step in IDLE, copy pending (including spike_in of that same cycle) into a send buffer and clear pending in the same edge.
REQ-017 SHALL implement FSM states IDLE, LOAD, SEND, DONE: IDLE->LOAD on time_step; LOAD->SEND if buffer non-zero, else LOAD->DONE; SEND->DONE when the last set bit is accepted; DONE->IDLE unconditionally.
REQ-018 SHALL, in LOAD and SEND, select the lowest set buffer bit i and present address = BASE_ADDR + i with addr_valid = 1 from the cycle after LOAD is entered.
REQ-019 SHALL treat a transfer as done when addr_valid and ready are both 1; on acceptance clear bit i and present the next lowest bit on the following cycle (one address per cycle at full throughput).
REQ-020 SHALL hold address and addr_valid stable while addr_valid = 1 and ready = 0.
REQ-021 SHALL drive address = 0 and addr_valid = 0 whenever no event is presented.
REQ-022 SHALL assert burst_done for exactly one cycle in DONE, including for an empty burst.
REQ-023 SHALL, on time_step while busy, set overrun, ignore that pulse, and keep accumulating into pending; those spikes go out with the next accepted time_step.
REQ-024 SHALL clear overrun on clr_overrun; a simultaneous overrun set wins.
REQ-025 SHALL compute BASE_ADDR + i modulo 2^ADDR_W (wrap, no saturation).
REQ-026 SHALL make latency time_step-to-first-address = 2 cycles.

Reset
REQ-027 SHALL, while rst = 0 at a clock edge, clear pending, send buffer, overrun, spike count; force IDLE; drive address = 0, addr_valid = 0, busy = 0, burst_done = 0.
REQ-028 SHALL abort any burst in progress on reset, with no further addresses and no burst_done.

Configuration
REQ-029 SHALL, with SPIKE_COUNT_EN defined, add output spike_count (16 bits) holding the number of addresses accepted in the last completed burst, updated in DONE and saturating at 0xFFFF.
REQ-030 SHALL, without SPIKE_COUNT_EN, omit the spike_count port and counter logic entirely.

Verification
REQ-031 SHALL verify: spikes on lines 0,2,5 then time_step, ready = 1 -> addresses 1,3,6 on consecutive cycles from 2 cycles after the pulse, then burst_done; spike_count = 3 if enabled.
REQ-032 SHALL verify: no spikes, time_step -> no addr_valid, burst_done 2 cycles after the pulse, spike_count = 0.
REQ-033 SHALL verify: lines 1,3 pending, ready low 4 cycles during the first address -> address 2 held 4 cycles, then 4, then burst_done.
REQ-034 SHALL verify: second time_step during a 3-event burst -> overrun = 1; a spike on line 7 in that window is emitted (address 8) after the next time_step; clr_overrun clears the flag.
REQ-035 SHALL verify: spike on line 4 in the same cycle as time_step -> address 5 emitted in that burst, and pending is empty afterwards.
REQ-036 SHALL verify: rst low mid-burst after 1 of 3 addresses -> next cycle address = 0, busy = 0; no burst_done.
